// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: fetch, data and memory-side handshake bundle for memory_arbiter
interface memory_arbiter_if #(
  parameter int ADDR_WIDTH = 10
);
  logic                  if_req;
  logic [ADDR_WIDTH-1:0] if_addr;
  logic [31:0]           if_rdata;
  logic                  if_ready;
  logic                  dm_req;
  logic                  dm_we;
  logic [ADDR_WIDTH-1:0] dm_addr;
  logic [31:0]           dm_wdata;
  logic [3:0]            dm_wmask;
  logic [31:0]           dm_rdata;
  logic                  dm_ready;
  logic                  mem_en;
  logic                  mem_we;
  logic [ADDR_WIDTH-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic [3:0]            mem_wmask;
  logic [31:0]           mem_rdata;
  logic                  mem_done;
  modport slave (
    input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wmask, mem_rdata, mem_done,
    output if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );
  modport master (
    output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wmask, mem_rdata, mem_done,
    input  if_rdata, if_ready, dm_rdata, dm_ready, mem_en, mem_we, mem_addr, mem_wdata, mem_wmask
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: data-priority fetch/data arbiter with starvation guard; MEM_ARB_TIMEOUT_EN adds wait-state abort
module memory_arbiter #(
  parameter int ADDR_WIDTH     = 10,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic              clk,
  input  logic              rst_n,
  memory_arbiter_if.slave   bus,
  output logic              busy,
  output logic              arb_error
);
  localparam int SW = $clog2(STARVE_LIMIT + 1);
  typedef enum logic [1:0] {IDLE, IF_WAIT, DM_WAIT} state_t;
  state_t                state_q, state_d;
  logic [SW-1:0]         starve_q, starve_d;
  logic                  mem_en_q, mem_en_d;
  logic                  mem_we_q, mem_we_d;
  logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d;
  logic [31:0]           mem_wdata_q, mem_wdata_d;
  logic [3:0]            mem_wmask_q, mem_wmask_d;
  logic                  timeout;
  logic                  fin;
  logic                  starved;
  logic                  fetch_first;
`ifdef MEM_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] wait_q, wait_d;
  // wait counter sits at zero in IDLE so each WAIT state starts counting from 0
  always_comb wait_d = (state_q == IDLE) ? '0 : wait_q + 1'b1;
  // wait counter register
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) wait_q <= '0;
    else wait_q <= wait_d;
  assign timeout = busy && !bus.mem_done && (wait_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign timeout = 1'b0;
`endif
  assign busy        = state_q != IDLE;
  assign fin         = busy && (bus.mem_done || timeout);
  assign arb_error   = timeout;
  assign starved     = starve_q == SW'(STARVE_LIMIT);
  assign fetch_first = bus.if_req && (!bus.dm_req || starved);
  // grant decision in IDLE, completion/abort in WAIT, starvation bookkeeping
  always_comb begin
    state_d     = state_q;
    starve_d    = starve_q;
    mem_en_d    = mem_en_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    mem_wmask_d = mem_wmask_q;
    if (state_q == IDLE && fetch_first) begin
      state_d     = IF_WAIT;
      starve_d    = '0;
      mem_en_d    = 1'b1;
      mem_we_d    = 1'b0;
      mem_addr_d  = bus.if_addr;
      mem_wdata_d = '0;
      mem_wmask_d = '0;
    end else if (state_q == IDLE && bus.dm_req) begin
      state_d     = DM_WAIT;
      starve_d    = !bus.if_req ? '0 : starved ? starve_q : starve_q + 1'b1;
      mem_en_d    = 1'b1;
      mem_we_d    = bus.dm_we;
      mem_addr_d  = bus.dm_addr;
      mem_wdata_d = bus.dm_wdata;
      mem_wmask_d = bus.dm_wmask;
    end else if (fin) begin
      state_d     = IDLE;
      mem_en_d    = 1'b0;
      mem_we_d    = 1'b0;
      mem_addr_d  = '0;
      mem_wdata_d = '0;
      mem_wmask_d = '0;
    end
  end
  // state, starvation count and memory-side output registers
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q     <= IDLE;
      starve_q    <= '0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_wmask_q <= '0;
    end else begin
      state_q     <= state_d;
      starve_q    <= starve_d;
      mem_en_q    <= mem_en_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      mem_wmask_q <= mem_wmask_d;
    end
  assign bus.mem_en    = mem_en_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_wmask = mem_wmask_q;
  assign bus.if_ready  = state_q == IF_WAIT && fin;
  assign bus.dm_ready  = state_q == DM_WAIT && fin;
  assign bus.if_rdata  = (state_q == IF_WAIT && bus.mem_done) ? bus.mem_rdata : '0;
  assign bus.dm_rdata  = (state_q == DM_WAIT && bus.mem_done && !mem_we_q) ? bus.mem_rdata : '0;
endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: cycle vector table plus scoreboarded memory-model sequences for memory_arbiter
module tb_memory_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic busy, arb_error;
  always #5 clk = ~clk;
  memory_arbiter_if #(.ADDR_WIDTH(10)) bus ();
  memory_arbiter #(.ADDR_WIDTH(10), .STARVE_LIMIT(4), .TIMEOUT_CYCLES(15)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus), .busy(busy), .arb_error(arb_error)
  );

  typedef struct {
    logic        ifr, dmr, dwe, done;
    logic [31:0] rd;
    logic [83:0] exp;
  } vec_t;

  int          total = 0;
  int          bad = 0;
  int          dm_pulses = 0;
  int          wcnt = 0;
  int          lat = 0;
  logic        auto_mem = 1'b0;
  logic        sb_on = 1'b0;
  logic        man_done = 1'b0;
  logic [31:0] man_rdata = '0;
  logic [31:0] model [1024];
  logic [31:0] if_q [$];
  logic [31:0] dm_q [$];
  string       ord = "";
  vec_t        vt [16];

  task automatic chk(input string n, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  function automatic logic [83:0] obs();
    return {busy, bus.mem_en, bus.mem_we, bus.mem_wmask, bus.mem_addr, bus.if_ready, bus.dm_ready,
            bus.if_rdata, bus.dm_rdata, arb_error};
  endfunction

  function automatic vec_t v(input logic ifr, dmr, dwe, done, input logic [31:0] rd,
                             input logic b, en, we, input logic [3:0] wm, input logic [9:0] ad,
                             input logic ir, dr, input logic [31:0] ird, drd);
    v.ifr  = ifr;
    v.dmr  = dmr;
    v.dwe  = dwe;
    v.done = done;
    v.rd   = rd;
    v.exp  = {b, en, we, wm, ad, ir, dr, ird, drd, 1'b0};
  endfunction

  // memory model: manual mode copies bench values, auto mode answers after lat wait cycles
  initial begin
    for (int a = 0; a < 1024; a++) model[a] = 32'h1000_0000 + a;
    bus.mem_done  = 1'b0;
    bus.mem_rdata = '0;
    forever begin
      @(posedge clk);
      #2;
      if (!auto_mem) begin
        bus.mem_done  = man_done;
        bus.mem_rdata = man_rdata;
      end else if (bus.mem_en && wcnt >= lat) begin
        bus.mem_done  = 1'b1;
        bus.mem_rdata = bus.mem_we ? 32'hDEAD_BEEF : model[bus.mem_addr];
        if (bus.mem_we)
          for (int b = 0; b < 4; b++)
            if (bus.mem_wmask[b]) model[bus.mem_addr][8*b +: 8] = bus.mem_wdata[8*b +: 8];
        wcnt = 0;
      end else begin
        bus.mem_done  = 1'b0;
        bus.mem_rdata = '0;
        wcnt = bus.mem_en ? wcnt + 1 : 0;
      end
    end
  end

  // scoreboard monitor: pop expected read data on each completion strobe
  initial forever begin
    @(negedge clk);
    if (bus.dm_ready) dm_pulses++;
    if (sb_on && bus.if_ready) begin
      ord = {ord, "F"};
      chk("if_pending", if_q.size() != 0, 1'b1);
      if (if_q.size() != 0) chk("if_rdata", bus.if_rdata, if_q.pop_front());
    end
    if (sb_on && bus.dm_ready) begin
      ord = {ord, "D"};
      chk("dm_pending", dm_q.size() != 0, 1'b1);
      if (dm_q.size() != 0) chk("dm_rdata", bus.dm_rdata, dm_q.pop_front());
    end
  end

  task automatic data_req(input logic we, input logic [9:0] a, input logic [31:0] wd,
                          input logic [3:0] m, input logic [31:0] exp);
    logic got = 1'b0;
    dm_q.push_back(we ? 32'h0 : exp);
    bus.dm_we    = we;
    bus.dm_addr  = a;
    bus.dm_wdata = wd;
    bus.dm_wmask = m;
    bus.dm_req   = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.dm_ready;
    end
    chk("dm_served", got, 1'b1);
    @(posedge clk);
    #1;
    bus.dm_req = 1'b0;
  endtask

  task automatic fetch_req(input logic [9:0] a, input logic [31:0] exp);
    logic got = 1'b0;
    if_q.push_back(exp);
    bus.if_addr = a;
    bus.if_req  = 1'b1;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      got = bus.if_ready;
    end
    chk("if_served", got, 1'b1);
    @(posedge clk);
    #1;
    bus.if_req = 1'b0;
  endtask

  initial begin
    int p0, n, errs;
    bus.if_req   = 1'b0;
    bus.if_addr  = 10'h004;
    bus.dm_req   = 1'b0;
    bus.dm_we    = 1'b0;
    bus.dm_addr  = 10'h010;
    bus.dm_wdata = 32'h1234_5678;
    bus.dm_wmask = 4'b0011;
    //          ifr dmr dwe done rd            busy en we wmask  addr    ir dr if_rdata      dm_rdata
    vt[0]  = v(1, 0, 0, 0, 32'h0,          0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);
    vt[1]  = v(1, 0, 0, 0, 32'h0,          1, 1, 0, 4'h0, 10'h004, 0, 0, 32'h0,          32'h0);
    vt[2]  = v(1, 0, 0, 0, 32'h0,          1, 1, 0, 4'h0, 10'h004, 0, 0, 32'h0,          32'h0);
    vt[3]  = v(1, 0, 0, 1, 32'h0050_0093,  1, 1, 0, 4'h0, 10'h004, 1, 0, 32'h0050_0093,  32'h0);
    vt[4]  = v(0, 0, 0, 1, 32'h0000_0001,  0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);
    vt[5]  = v(1, 1, 1, 0, 32'h0,          0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);
    vt[6]  = v(1, 1, 1, 0, 32'h0,          1, 1, 1, 4'h3, 10'h010, 0, 0, 32'h0,          32'h0);
    vt[7]  = v(1, 1, 1, 1, 32'hDEAD_BEEF,  1, 1, 1, 4'h3, 10'h010, 0, 1, 32'h0,          32'h0);
    vt[8]  = v(1, 0, 0, 0, 32'h0,          0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);
    vt[9]  = v(1, 0, 0, 1, 32'hCAFE_F00D,  1, 1, 0, 4'h0, 10'h004, 1, 0, 32'hCAFE_F00D,  32'h0);
    vt[10] = v(0, 1, 0, 0, 32'h0,          0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);
    vt[11] = v(0, 1, 0, 1, 32'h1122_3344,  1, 1, 0, 4'h3, 10'h010, 0, 1, 32'h0,          32'h1122_3344);
    vt[12] = v(1, 0, 0, 0, 32'h0,          0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);
    vt[13] = v(0, 0, 0, 0, 32'h0,          1, 1, 0, 4'h0, 10'h004, 0, 0, 32'h0,          32'h0);
    vt[14] = v(0, 0, 0, 1, 32'hA5A5_A5A5,  1, 1, 0, 4'h0, 10'h004, 1, 0, 32'hA5A5_A5A5,  32'h0);
    vt[15] = v(0, 0, 0, 0, 32'h0,          0, 0, 0, 4'h0, 10'h000, 0, 0, 32'h0,          32'h0);

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("reset_outputs", obs(), 84'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      bus.if_req = vt[i].ifr;
      bus.dm_req = vt[i].dmr;
      bus.dm_we  = vt[i].dwe;
      man_done   = vt[i].done;
      man_rdata  = vt[i].rd;
      @(negedge clk);
      chk($sformatf("vec%0d", i), obs(), vt[i].exp);
    end

    // reset in the middle of a data wait
    @(posedge clk);
    #1;
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b0;
    man_done   = 1'b0;
    @(posedge clk);
    #1;
    @(negedge clk);
    chk("pre_reset_busy", busy, 1'b1);
    p0 = dm_pulses;
    @(posedge clk);
    #1;
    rst_n     = 1'b0;
    man_done  = 1'b1;
    man_rdata = 32'h7777_7777;
    @(negedge clk);
    chk("rst_mem_en", bus.mem_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_dm_ready", bus.dm_ready, 1'b0);
    @(posedge clk);
    #1;
    rst_n      = 1'b1;
    bus.dm_req = 1'b0;
    man_done   = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_no_resume", busy, 1'b0);
    chk("rst_no_ready", dm_pulses - p0, 0);

`ifdef MEM_ARB_TIMEOUT_EN
    // stalled memory: abort expected in the 15th wait cycle
    @(posedge clk);
    #1;
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b0;
    man_rdata  = 32'h5555_AAAA;
    n = 0;
    errs = 0;
    for (int i = 0; i < 40 && errs == 0; i++) begin
      @(negedge clk);
      if (busy) n++;
      if (arb_error) errs = 1;
    end
    chk("to_cycle", n, 15);
    chk("to_dm_ready", bus.dm_ready, 1'b1);
    chk("to_dm_rdata", bus.dm_rdata, 32'h0);
    @(posedge clk);
    #1;
    bus.dm_req = 1'b0;
    @(negedge clk);
    chk("to_idle", {busy, arb_error}, 2'b00);
`else
    // stalled memory: wait lasts indefinitely with no abort
    @(posedge clk);
    #1;
    bus.dm_req = 1'b1;
    bus.dm_we  = 1'b0;
    errs = 0;
    repeat (25) begin
      @(negedge clk);
      if (arb_error || bus.dm_ready) errs++;
    end
    chk("no_abort", errs, 0);
    chk("still_busy", busy, 1'b1);
    @(posedge clk);
    #1;
    man_done  = 1'b1;
    man_rdata = 32'h0BAD_F00D;
    @(negedge clk);
    chk("late_done_ready", bus.dm_ready, 1'b1);
    chk("late_done_rdata", bus.dm_rdata, 32'h0BAD_F00D);
    @(posedge clk);
    #1;
    bus.dm_req = 1'b0;
    man_done   = 1'b0;
    @(negedge clk);
    chk("late_idle", busy, 1'b0);
`endif

    // scoreboarded traffic against the memory model
    auto_mem = 1'b1;
    sb_on    = 1'b1;
    lat      = 0;
    @(posedge clk);
    #1;
    data_req(1'b0, 10'h040, 32'h0, 4'h0, 32'h1000_0040);
    ord = "";
    fork
      fetch_req(10'h004, 32'h1000_0004);
      for (int i = 0; i < 5; i++) data_req(1'b0, 10'(32'h20 + i), 32'h0, 4'h0, 32'h1000_0020 + i);
    join
    chk("grant_order_DDDDFD", ord == "DDDDFD", 1'b1);
    lat = 2;
    data_req(1'b1, 10'h030, 32'hA5A5_5A5A, 4'b0101, 32'h0);
    data_req(1'b0, 10'h030, 32'h0, 4'h0, 32'h10A5_005A);
    lat = 3;
    fetch_req(10'h3FF, 32'h1000_03FF);
    repeat (2) @(negedge clk);
    chk("if_q_drained", if_q.size(), 0);
    chk("dm_q_drained", dm_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/memory_arbiter.md
MEMORY_ARBITER -- requirements
Module: memory_arbiter

Interface
REQ-001 Parameter ADDR_WIDTH, default 10, word-address width on all address ports.
REQ-002 Parameter STARVE_LIMIT, default 4, maximum consecutive data grants while fetch waits.
REQ-003 Parameter TIMEOUT_CYCLES, default 15, wait-state limit before abort; used only with MEM_ARB_TIMEOUT_EN.
REQ-004 clk  in  1  single clock; all state updates on the rising edge.
REQ-005 reset  in  1  asynchronous, active-low reset.
REQ-006 if_req  in  1  fetch-read request; held with if_addr stable until if_ready.
REQ-007 if_addr  in  ADDR_WIDTH  fetch word address.
REQ-008 if_rdata  out  32  fetch read data; valid only while if_ready=1.
REQ-009 if_ready  out  1  fetch completion strobe.
REQ-010 dm_req  in  1  data request; held with dm_we, dm_addr, dm_wdata and dm_wmask stable until dm_ready.
REQ-011 dm_we  in  1  data request type: 1 = store, 0 = load.
REQ-012 dm_addr  in  ADDR_WIDTH  data word address.
REQ-013 dm_wdata  in  32  store data.
REQ-014 dm_wmask  in  4  store byte mask.
REQ-015 dm_rdata  out  32  load data; valid only while dm_ready=1.
REQ-016 dm_ready  out  1  data completion strobe.
REQ-017 mem_en, mem_we  out  1 each  memory access enable and write enable.
REQ-018 mem_addr, mem_wdata, mem_wmask  out  ADDR_WIDTH, 32 and 4  memory address, write data and byte mask.
REQ-019 mem_rdata  in  32  memory read data; mem_done  in  1  memory completion.
REQ-020 busy  out  1  high whenever the FSM is not in IDLE.
REQ-021 arb_error  out  1  one-cycle abort pulse; tied to 0 without MEM_ARB_TIMEOUT_EN.

Function
REQ-022 FSM states are IDLE, IF_WAIT and DM_WAIT; state is registered.
REQ-023 IDLE samples requests at the clock edge and moves to IF_WAIT or DM_WAIT according to the grant; with no request it stays in IDLE.
REQ-024 Grant priority: data wins over fetch, except that fetch wins when both requests are high and starve_cnt equals STARVE_LIMIT.
REQ-025 starve_cnt rules:
- increments on a data grant while if_req=1;
- clears on any fetch grant, or on a data grant while if_req=0;
- saturates at STARVE_LIMIT.
REQ-026 Memory-side outputs are registered at grant time and held constant for the whole WAIT state.
REQ-027 mem_en=1 throughout both WAIT states; mem_en=0 in IDLE.
REQ-028 IF_WAIT drives mem_we=0, mem_wmask=0 and mem_addr=if_addr.
REQ-029 DM_WAIT drives mem_we=dm_we, mem_addr=dm_addr, mem_wdata=dm_wdata and mem_wmask=dm_wmask.
REQ-030 if_ready equals (state==IF_WAIT && mem_done) combinationally; if_rdata=mem_rdata in that cycle, otherwise 0.
REQ-031 dm_ready equals (state==DM_WAIT && mem_done) combinationally; dm_rdata=mem_rdata for loads in that cycle, otherwise 0.
REQ-032 On the edge where mem_done is sampled in a WAIT state, the FSM returns to IDLE.
REQ-033 Minimum latency: request in cycle 0 gives ready in cycle 1; back-to-back grants are separated by one IDLE cycle.
REQ-034 mem_done in IDLE is ignored; a request deasserted during WAIT does not abort the access.
REQ-035 Simultaneous requests while starve_cnt < STARVE_LIMIT grant data.

Reset
REQ-036 Asserting reset, including mid-transaction, forces IDLE immediately.
REQ-037 Reset clears starve_cnt, the timeout counter and all registered outputs.
REQ-038 During reset: mem_en=0, mem_we=0, busy=0, arb_error=0 and both ready strobes 0; no partial transaction is resumed.

Configuration
REQ-039 Macro MEM_ARB_TIMEOUT_EN defined:
- a wait counter clears on entry to each WAIT state and increments each WAIT cycle without mem_done;
- when the counter reaches TIMEOUT_CYCLES, the FSM returns to IDLE and pulses the active requester's ready with rdata=0 and arb_error=1 for one cycle;
- mem_done in the same cycle takes precedence as a normal completion.
REQ-040 Macro MEM_ARB_TIMEOUT_EN undefined: no counter exists, WAIT states last indefinitely, and arb_error is constant 0.

Verification
REQ-041 Fetch only: if_addr=0x004 and mem_done after 2 WAIT cycles with mem_rdata=0x00500093 -> if_ready high in cycle 3, if_rdata=0x00500093, mem_we=0 throughout.
REQ-042 Simultaneous requests: dm_req store to addr 0x010 with wmask=4'b0011 and if_req -> DM_WAIT first with mem_we=1 and mem_wmask=4'b0011; fetch granted after the following IDLE cycle.
REQ-043 Starvation: if_req held high, with 5 back-to-back data requests and mem_done immediate -> grants are D,D,D,D,F and the 5th data request is served after the fetch.
REQ-044 Reset mid-DM_WAIT: reset driven low for 1 cycle -> mem_en=0, busy=0 and dm_ready never pulses; a fresh request after reset release completes normally.
REQ-045 With MEM_ARB_TIMEOUT_EN: mem_done held at 0 -> arb_error and dm_ready pulse in the 15th WAIT cycle, dm_rdata=0, FSM returns to IDLE.
